// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_check_pkg;

  localparam int unsigned DEFAULT_SETTLE = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Number of stimulus vectors in an exhaustive sweep of n_in bits.
  function automatic int unsigned n_vectors(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_checker_impl_compare.sv
// Combinational comparison of every implementation slice against slice 0.
module impl_compare #(
  parameter int unsigned N_IMPL = 3,
  parameter int unsigned N_OUT  = 3
) (
  input  logic [N_IMPL*N_OUT-1:0] resp,
  output logic                    any_mismatch,
  output logic [N_IMPL*N_OUT-1:0] diff_mask
);

  // Per-bit difference of each slice from the golden slice; slice 0 stays zero.
  always_comb begin
    diff_mask = '0;
    for (int unsigned k = 1; k < N_IMPL; k++) begin
      diff_mask[k*N_OUT +: N_OUT] = resp[k*N_OUT +: N_OUT] ^ resp[N_OUT-1:0];
    end
  end

  assign any_mismatch = |diff_mask;

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive sweep engine: drives every stim vector, samples N_IMPL response
// slices after a settle interval and records mismatches against slice 0.
// Optional macro TT_CHECK_BITMASK_EN adds the sticky per-bit err_mask output.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 3,
  parameter int unsigned N_IMPL = 3,
  parameter int unsigned SETTLE = DEFAULT_SETTLE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [N_IN-1:0]         stim,
  input  logic [N_IMPL*N_OUT-1:0] resp,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic [N_IN-1:0]         first_err_vec,
  output logic                    first_err_valid
`ifdef TT_CHECK_BITMASK_EN
  ,
  output logic [N_IMPL*N_OUT-1:0] err_mask
`endif
);

  localparam int unsigned RESP_W = N_IMPL * N_OUT;
  localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(n_vectors(N_IN) - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_d;
  logic [N_IN:0]     err_count_d;
  logic [N_IN-1:0]   first_err_vec_d;
  logic              first_err_valid_d;
  logic              busy_d, done_d, pass_d;
  logic              any_mismatch;
  logic [RESP_W-1:0] diff_mask;
`ifdef TT_CHECK_BITMASK_EN
  logic [RESP_W-1:0] err_mask_d;
`else
  logic              unused_diff;
  assign unused_diff = ^diff_mask;
`endif

  impl_compare #(
    .N_IMPL (N_IMPL),
    .N_OUT  (N_OUT)
  ) u_cmp (
    .resp         (resp),
    .any_mismatch (any_mismatch),
    .diff_mask    (diff_mask)
  );

  // Next-state, sweep counters and result updates.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    stim_d            = stim;
    err_count_d       = err_count;
    first_err_vec_d   = first_err_vec;
    first_err_valid_d = first_err_valid;
`ifdef TT_CHECK_BITMASK_EN
    err_mask_d        = err_mask;
`endif
    case (state_q)
      tt_check_pkg::IDLE, tt_check_pkg::DONE: begin
        if (start) begin
          state_d           = tt_check_pkg::SETTLE;
          cnt_d             = '0;
          stim_d            = '0;
          err_count_d       = '0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
`ifdef TT_CHECK_BITMASK_EN
          err_mask_d        = '0;
`endif
        end
      end
      tt_check_pkg::SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = tt_check_pkg::SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      tt_check_pkg::SAMPLE: begin
        if (any_mismatch) begin
          err_count_d = err_count + (N_IN+1)'(1);
          if (!first_err_valid) begin
            first_err_vec_d   = stim;
            first_err_valid_d = 1'b1;
          end
        end
`ifdef TT_CHECK_BITMASK_EN
        err_mask_d = err_mask | diff_mask;
`endif
        if (stim == LAST_VEC) begin
          state_d = tt_check_pkg::DONE;
        end else begin
          stim_d  = stim + N_IN'(1);
          cnt_d   = '0;
          state_d = tt_check_pkg::SETTLE;
        end
      end
      default: state_d = tt_check_pkg::IDLE;
    endcase
    busy_d = (state_d == tt_check_pkg::SETTLE) || (state_d == tt_check_pkg::SAMPLE);
    done_d = (state_d == tt_check_pkg::DONE);
    pass_d = done_d && (err_count_d == '0);
  end

  // State and registered outputs; reset discards any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= tt_check_pkg::IDLE;
      cnt_q           <= '0;
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
`ifdef TT_CHECK_BITMASK_EN
      err_mask        <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      stim            <= stim_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_count       <= err_count_d;
      first_err_vec   <= first_err_vec_d;
      first_err_valid <= first_err_valid_d;
`ifdef TT_CHECK_BITMASK_EN
      err_mask        <= err_mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: two checkers (N_IN=2/SETTLE=1 and N_IN=4/SETTLE=3) share
// start/rst_n and a per-vector fault table applied to three AND/OR/XOR models.
module tb_truth_table_checker;

  typedef struct {
    int done_cyc;
    int errs;
    int first_vec;
    int first_valid;
    int pass_e;
    int mask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;
  logic [8:0] flip [16];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // DUT A: defaults
  logic [1:0] stim_a;  logic [8:0] resp_a;
  logic busy_a, done_a, pass_a, fev_valid_a;
  logic [2:0] err_a;   logic [1:0] fev_a;
  // DUT B: N_IN=4, SETTLE=3
  logic [3:0] stim_b;  logic [8:0] resp_b;
  logic busy_b, done_b, pass_b, fev_valid_b;
  logic [4:0] err_b;   logic [3:0] fev_b;
`ifdef TT_CHECK_BITMASK_EN
  logic [8:0] mask_a, mask_b;
`endif

  always_comb resp_a = {3{^stim_a, |stim_a, &stim_a}} ^ flip[{2'b00, stim_a}];
  always_comb resp_b = {3{^stim_b, |stim_b, &stim_b}} ^ flip[stim_b];

  truth_table_checker u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_vec(fev_a), .first_err_valid(fev_valid_a)
`ifdef TT_CHECK_BITMASK_EN
    , .err_mask(mask_a)
`endif
  );

  truth_table_checker #(.N_IN(4), .N_OUT(3), .N_IMPL(3), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_vec(fev_b), .first_err_valid(fev_valid_b)
`ifdef TT_CHECK_BITMASK_EN
    , .err_mask(mask_b)
`endif
  );

  logic [3:0] o_stim [2];
  logic [4:0] o_err [2];
  logic [3:0] o_fev [2];
  logic o_busy [2], o_done [2], o_pass [2], o_fv [2];
  assign o_stim[0] = 4'(stim_a);  assign o_stim[1] = stim_b;
  assign o_err[0]  = 5'(err_a);   assign o_err[1]  = err_b;
  assign o_fev[0]  = 4'(fev_a);   assign o_fev[1]  = fev_b;
  assign o_busy[0] = busy_a;      assign o_busy[1] = busy_b;
  assign o_done[0] = done_a;      assign o_done[1] = done_b;
  assign o_pass[0] = pass_a;      assign o_pass[1] = pass_b;
  assign o_fv[0]   = fev_valid_a; assign o_fv[1]   = fev_valid_b;
`ifdef TT_CHECK_BITMASK_EN
  logic [8:0] o_mask [2];
  assign o_mask[0] = mask_a;      assign o_mask[1] = mask_b;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction
  function automatic exp_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction
  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction
  function automatic void qpush(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction
  function automatic void qclear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
  endfunction

  function automatic int nvec(input int d);
    return (d == 0) ? 4 : 16;
  endfunction
  function automatic int settle(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: the expected sweep outcome from the fault table and the
  // arithmetic definition of AND/OR/XOR over the vector value.
  function automatic exp_t model(input int d, input int t_start);
    exp_t e;
    logic [2:0] g;
    logic [8:0] r;
    logic [2:0] dk;
    bit mism;
    int nv;
    nv = nvec(d);
    e.done_cyc = t_start + 1 + nv * (settle(d) + 1);
    e.errs = 0; e.first_vec = 0; e.first_valid = 0; e.mask = 0;
    for (int v = 0; v < nv; v++) begin
      g[0] = (v == nv - 1);
      g[1] = (v != 0);
      g[2] = 1'($countones(v) % 2);
      r = {g, g, g} ^ flip[v];
      mism = 1'b0;
      for (int k = 1; k < 3; k++) begin
        dk = r[k*3 +: 3] ^ r[2:0];
        if (dk != 3'b000) mism = 1'b1;
        e.mask = e.mask | (int'(dk) << (k * 3));
      end
      if (mism) begin
        if (e.first_valid == 0) begin
          e.first_vec = v;
          e.first_valid = 1;
        end
        e.errs++;
      end
    end
    e.pass_e = (e.errs == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, d, got, want, cyc);
    end
  endtask

  bit act [2];
  int t0 [2];
  int dc [2];
  bit done_prev [2];

  // Monitor: timing model, per-cycle checks and scoreboard pop on done.
  always @(negedge clk) begin
    exp_t e;
    bit eb;
    bit ed;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        chk("rst_stim", d, int'(o_stim[d]), 0);
        chk("rst_busy", d, int'(o_busy[d]), 0);
        chk("rst_done", d, int'(o_done[d]), 0);
        chk("rst_pass", d, int'(o_pass[d]), 0);
        chk("rst_err_count", d, int'(o_err[d]), 0);
        chk("rst_first_vec", d, int'(o_fev[d]), 0);
        chk("rst_first_valid", d, int'(o_fv[d]), 0);
`ifdef TT_CHECK_BITMASK_EN
        chk("rst_err_mask", d, int'(o_mask[d]), 0);
`endif
        act[d] = 1'b0;
        done_prev[d] = 1'b0;
        qclear(d);
      end else begin
        eb = act[d] && (cyc > t0[d]) && (cyc < dc[d]);
        ed = act[d] && (cyc >= dc[d]);
        chk("busy", d, int'(o_busy[d]), int'(eb));
        chk("done", d, int'(o_done[d]), int'(ed));
        if (eb) chk("stim", d, int'(o_stim[d]), (cyc - t0[d] - 1) / (settle(d) + 1));
        if (act[d] && cyc == t0[d] + 1) begin
          chk("clr_err_count", d, int'(o_err[d]), 0);
          chk("clr_first_valid", d, int'(o_fv[d]), 0);
          chk("clr_pass", d, int'(o_pass[d]), 0);
        end
        if (o_done[d] && !done_prev[d]) begin
          if (qsize(d) == 0) begin
            chk("unexpected_done", d, 1, 0);
          end else begin
            e = qpop(d);
            chk("done_cycle", d, cyc, e.done_cyc);
            chk("err_count", d, int'(o_err[d]), e.errs);
            chk("first_err_valid", d, int'(o_fv[d]), e.first_valid);
            chk("first_err_vec", d, int'(o_fev[d]), e.first_vec);
            chk("pass", d, int'(o_pass[d]), e.pass_e);
`ifdef TT_CHECK_BITMASK_EN
            chk("err_mask", d, int'(o_mask[d]), e.mask);
`endif
          end
        end else if (qsize(d) != 0) begin
          e = qfront(d);
          if (cyc > e.done_cyc + 2) begin
            chk("done_timeout", d, cyc, e.done_cyc);
            e = qpop(d);
          end
        end
        done_prev[d] = o_done[d];
        if (start && !(act[d] && cyc < dc[d])) begin
          qpush(d, model(d, cyc));
          act[d] = 1'b1;
          t0[d] = cyc;
          dc[d] = cyc + 1 + nvec(d) * (settle(d) + 1);
        end
      end
    end
  end

  task automatic pulse_start_after(input int n);
    repeat (n) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic set_flips(input logic [8:0] val);
    for (int v = 0; v < 16; v++) flip[v] = val;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_flips(9'h000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // identical models
    pulse_start_after(2);
    wait_idle(300);

    // impl 2 y3 inverted at vector 3 only
    #2 flip[3] = 9'h100;
    pulse_start_after(1);
    wait_idle(300);

    // impl 1 y1 always inverted
    #2 set_flips(9'h008);
    pulse_start_after(1);
    wait_idle(300);

    // ignored start mid-sweep, restart from DONE, then reset mid-sweep
    #2 set_flips(9'h000);
    pulse_start_after(1);
    pulse_start_after(2);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (q0.size() == 0) break;
    end
    pulse_start_after(1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pulse_start_after(1);
    wait_idle(300);

    // mismatches at vectors 5 and 12
    #2 flip[5] = 9'h010;
    flip[12] = 9'h040;
    pulse_start_after(1);
    wait_idle(300);

    // random fault tables with occasional ignored starts
    for (int it = 0; it < 8; it++) begin
      #2;
      for (int v = 0; v < 16; v++)
        flip[v] = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h000;
      pulse_start_after(1);
      if ($urandom_range(0, 1) == 1) pulse_start_after($urandom_range(1, 6));
      wait_idle(300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
